// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: controller state encoding and protocol constants.
package tm1638_pkg;

  // Read-engine states; 4-bit encoding is also exposed on the diagnostic port.
  typedef enum logic [3:0] {
    StIdle       = 4'd0,
    StLoad       = 4'd1,
    StCmdLow     = 4'd2,
    StCmdHigh    = 4'd3,
    StTurnaround = 4'd4,
    StRxLow      = 4'd5,
    StRxHigh     = 4'd6,
    StPause      = 4'd7
  } tm1638_state_e;

  localparam logic [7:0]  TM1638_CMD_READ_KEYS = 8'h42;
  localparam int unsigned TM1638_KEY_BITS      = 32;

endpackage

// File: rtl/tm1638_key_reader_if.sv
// Request/response and SPI pin bundle of the TM1638 key reader.
// slave: the reader block. master: the controller that owns it.
interface tm1638_key_reader_if;
  import tm1638_pkg::*;

  logic                       i_Start;
  logic                       o_Busy;
  logic [TM1638_KEY_BITS-1:0] o_Data;
  logic                       o_Data_Valid;
  logic                       o_SPI_Stb;
  logic                       o_SPI_Clk;
  logic                       o_SPI_Dio;
  logic                       o_SPI_Dio_Oe;
  logic                       i_SPI_Dio;

  modport slave (
    input  i_Start, i_SPI_Dio,
    output o_Busy, o_Data, o_Data_Valid, o_SPI_Stb, o_SPI_Clk, o_SPI_Dio, o_SPI_Dio_Oe
  );

  modport master (
    output i_Start, i_SPI_Dio,
    input  o_Busy, o_Data, o_Data_Valid, o_SPI_Stb, o_SPI_Clk, o_SPI_Dio, o_SPI_Dio_Oe
  );

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; o_Done is high while the count sits at zero.
// Loading N gives N+1 cycles before the next terminal count.
module spi_phase_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Value,
  output logic             o_Done
);

  logic [WIDTH-1:0] count_q;

  assign o_Done = (count_q == '0);

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count_q <= '0;
    end else if (i_Load) begin
      count_q <= i_Value;
    end else if (!o_Done) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends command 0x42, releases DIO, clocks in 32 key bits LSB first.
// Optional diagnostic ports are enabled with TM1638_KEY_READER_DIAG_EN.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int unsigned CYCLES      = 1,
  parameter int unsigned WAIT_CYCLES = 25
) (
  input logic                i_Clk,
  input logic                i_Rst,
  tm1638_key_reader_if.slave bus
`ifdef TM1638_KEY_READER_DIAG_EN
  ,
  output logic [3:0]                 o_Diag_State,
  output logic [4:0]                 o_Diag_Bit,
  output logic [TM1638_KEY_BITS-1:0] o_Diag_Shift
`endif
);

  if (CYCLES < 1) begin : g_bad_cycles
    $error("CYCLES must be at least 1");
  end
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("WAIT_CYCLES must be at least 1");
  end

  localparam logic [15:0] PhaseLoad = 16'(CYCLES);
  localparam logic [15:0] WaitLoad  = 16'(WAIT_CYCLES - 1);

  tm1638_state_e              state_q, state_d;
  logic [4:0]                 bit_q, bit_d;
  logic [TM1638_KEY_BITS-1:0] shift_q, shift_d;
  logic [TM1638_KEY_BITS-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       dio_meta_q, dio_sync_q;
  logic                       tmr_load, tmr_done;
  logic [15:0]                tmr_value;
  logic                       stb, sclk, dio, oe;

  spi_phase_timer #(
    .WIDTH (16)
  ) u_phase_timer (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Load  (tmr_load),
    .i_Value (tmr_value),
    .o_Done  (tmr_done)
  );

  // Two-flop synchronizer for the asynchronous DIO pin.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      dio_meta_q <= 1'b0;
      dio_sync_q <= 1'b0;
    end else begin
      dio_meta_q <= bus.i_SPI_Dio;
      dio_sync_q <= dio_meta_q;
    end
  end

  // State, bit index, shift register and result registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, phase timer reload and pin decode.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = PhaseLoad;
    stb       = 1'b1;
    sclk      = 1'b1;
    dio       = 1'b0;
    oe        = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.i_Start) begin
          state_d   = StLoad;
          tmr_load  = 1'b1;
          tmr_value = '0;
        end
      end
      StLoad: begin
        bit_d    = '0;
        shift_d  = '0;
        state_d  = StCmdLow;
        tmr_load = 1'b1;
      end
      StCmdLow: begin
        stb  = 1'b0;
        sclk = 1'b0;
        oe   = 1'b1;
        dio  = TM1638_CMD_READ_KEYS[bit_q[2:0]];
        if (tmr_done) begin
          state_d  = StCmdHigh;
          tmr_load = 1'b1;
        end
      end
      StCmdHigh: begin
        stb = 1'b0;
        oe  = 1'b1;
        dio = TM1638_CMD_READ_KEYS[bit_q[2:0]];
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (bit_q == 5'd7) begin
            bit_d     = '0;
            state_d   = StTurnaround;
            tmr_value = WaitLoad;
          end else begin
            bit_d   = bit_q + 5'd1;
            state_d = StCmdLow;
          end
        end
      end
      StTurnaround: begin
        stb = 1'b0;
        if (tmr_done) begin
          state_d  = StRxLow;
          tmr_load = 1'b1;
        end
      end
      StRxLow: begin
        stb  = 1'b0;
        sclk = 1'b0;
        if (tmr_done) begin
          state_d  = StRxHigh;
          tmr_load = 1'b1;
        end
      end
      StRxHigh: begin
        stb = 1'b0;
        if (tmr_done) begin
          // Sample late in the high phase so the synchronizer has caught up.
          shift_d[bit_q] = dio_sync_q;
          bit_d          = bit_q + 5'd1;
          tmr_load       = 1'b1;
          state_d        = (bit_q == 5'd31) ? StPause : StRxLow;
        end
      end
      StPause: begin
        if (tmr_done) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.o_Busy       = (state_q != StIdle);
  assign bus.o_Data       = data_q;
  assign bus.o_Data_Valid = valid_q;
  assign bus.o_SPI_Stb    = stb;
  assign bus.o_SPI_Clk    = sclk;
  assign bus.o_SPI_Dio    = dio;
  assign bus.o_SPI_Dio_Oe = oe;

`ifdef TM1638_KEY_READER_DIAG_EN
  assign o_Diag_State = state_q;
  assign o_Diag_Bit   = bit_q;
  assign o_Diag_Shift = shift_q;
`endif

endmodule
